// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: merges memory busywaits, load-use
// bubbles and branch flushes, and drains/freezes the pipeline around a cache context switch.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_mem_busywait,
    input  logic       d_mem_busywait,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_write_address,
    input  logic       ex_d_mem_r,
    input  logic       branch_jump_signal,
    input  logic       ctx_switch_req,
    input  logic       ctx_switch_done,
    output logic       pc_stall,
    output logic       if_id_busywait,
    output logic       if_id_flush,
    output logic       id_ex_busywait,
    output logic       id_ex_flush,
    output logic       ex_mem_busywait,
    output logic       mem_wb_busywait,
    output logic       ctx_switch_ack
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH, RESUME} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic            mem_busy, lu, bj, lu_kept;

    assign mem_busy = i_mem_busywait | d_mem_busywait;
    assign lu = ex_d_mem_r & (ex_write_address != 5'd0) &
                ((id_uses_rs1 & (id_rs1_addr == ex_write_address)) |
                 (id_uses_rs2 & (id_rs2_addr == ex_write_address)));
    // A branch resolved while EX is held by a data stall must not be flushed away.
    assign bj = branch_jump_signal & ~d_mem_busywait;
    // A taken branch kills the dependent instruction, so no bubble is needed.
    assign lu_kept = lu & ~bj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        pc_stall        = 1'b0;
        if_id_busywait  = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_busywait  = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_busywait = 1'b0;
        mem_wb_busywait = 1'b0;
        ctx_switch_ack  = 1'b0;
        // Outputs are gated by reset so they drop immediately, not at the next edge.
        if (reset) begin
            case (state)
                RUN: begin
                    pc_stall        = mem_busy | lu_kept;
                    if_id_busywait  = mem_busy | lu_kept;
                    if_id_flush     = bj;
                    id_ex_busywait  = mem_busy;
                    id_ex_flush     = bj | (lu_kept & ~mem_busy);
                    ex_mem_busywait = mem_busy;
                    mem_wb_busywait = mem_busy;
                    if (ctx_switch_req) begin
                        state_next = DRAIN;
                        count_next = CW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    pc_stall        = 1'b1;
                    if_id_busywait  = 1'b1;
                    if_id_flush     = bj;
                    id_ex_busywait  = mem_busy;
                    id_ex_flush     = 1'b1;
                    ex_mem_busywait = mem_busy;
                    mem_wb_busywait = mem_busy;
                    // Retirement only progresses while the data side is not stalling.
                    if (!d_mem_busywait && count != '0) begin
                        count_next = count - CW'(1);
                        if (count == CW'(1)) begin
                            state_next = SWITCH;
                        end
                    end
                end
                SWITCH: begin
                    pc_stall        = 1'b1;
                    if_id_busywait  = 1'b1;
                    id_ex_busywait  = 1'b1;
                    ex_mem_busywait = 1'b1;
                    mem_wb_busywait = 1'b1;
                    ctx_switch_ack  = 1'b1;
                    if (ctx_switch_done) begin
                        state_next = RESUME;
                    end
                end
                RESUME: begin
                    if_id_flush = 1'b1;
                    state_next  = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule
